// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic OP_MUL = 1'b1;
    localparam logic OP_DIV = 1'b0;

    localparam int unsigned          MAX_WIDTH   = 64;
    localparam logic [MAX_WIDTH-1:0] DIV0_RESULT = '1;

endpackage

// File: rtl/muldiv_iter_core.sv
// Iteration datapath: shift-add multiply or restoring divide, one step per enabled edge.
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res
);

    // acc: product accumulator or partial remainder.
    // opa: shifting multiplicand, or dividend shifting out while quotient bits shift in.
    // opb: shifting multiplier, or the static divisor.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    always_comb begin
        shifted = {acc, opa[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, opb};
        borrow  = diff[WIDTH+1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            opa <= '0;
            opb <= '0;
        end else if (load) begin
            acc <= '0;
            opa <= a;
            opb <= b;
        end else if (step) begin
            if (op == OP_MUL) begin
                if (opb[0]) begin
                    acc <= acc + opa;
                end
                opa <= {opa[WIDTH-2:0], 1'b0};
                opb <= {1'b0, opb[WIDTH-1:1]};
            end else begin
                // Remainder stays below the divisor, so on borrow the shifted value fits WIDTH bits.
                acc <= borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                opa <= {opa[WIDTH-2:0], ~borrow};
            end
        end
    end

    assign res = (op == OP_MUL) ? acc : opa;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer: FSM, iteration counter, sign fixup and result registers.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_mul,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int unsigned    CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic             op_r;
    logic             neg_r;
    logic             load;
    logic             step;
    logic             div0;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] core_res;

    always_comb begin
        div0  = (op_mul == OP_DIV) && (src_b == '0);
        a_neg = (op_mul == OP_DIV) && div_signed && src_a[WIDTH-1];
        b_neg = (op_mul == OP_DIV) && div_signed && src_b[WIDTH-1];
        a_mag = a_neg ? -src_a : src_a;
        b_mag = b_neg ? -src_b : src_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        stall   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (div0) begin
                        state_n = DONE;
                    end else begin
                        state_n = RUN;
                        load    = 1'b1;
                        stall   = 1'b1;
                    end
                end
            end
            RUN: begin
                step  = 1'b1;
                stall = 1'b1;
                if (cnt == LAST) begin
                    state_n = FIXUP;
                end
            end
            FIXUP: begin
                stall   = 1'b1;
                state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            op_r        <= 1'b0;
            neg_r       <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (div0) begin
                            result      <= DIV0_RESULT[WIDTH-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            op_r        <= op_mul;
                            neg_r       <= a_neg ^ b_neg;
                            cnt         <= '0;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                end
                FIXUP: begin
                    result <= neg_r ? -core_res : core_res;
                end
                default: begin
                end
            endcase
        end
    end

    muldiv_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .step (step),
        .op   (op_r),
        .a    (a_mag),
        .b    (b_mag),
        .res  (core_res)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed corner cases plus random operations.
module tb_muldiv_sequencer;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op_mul;
    logic         div_signed;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] result;
    logic         div_by_zero;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_mul     (op_mul),
        .div_signed (div_signed),
        .src_a      (src_a),
        .src_b      (src_b),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .result     (result),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         dbz;
        int unsigned  due;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operand values.
    function automatic exp_t model(input bit op, input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa;
        longint      sb;
        longint      qq;
        e.due = 0;
        e.dbz = 1'b0;
        if (op) begin
            p     = {32'b0, a} * {32'b0, b};
            e.res = p[W-1:0];
        end else if (b == 0) begin
            e.res = '1;
            e.dbz = 1'b1;
        end else if (!sgn) begin
            e.res = a / b;
        end else begin
            sa    = longint'($signed(a));
            sb    = longint'($signed(b));
            qq    = sa / sb;
            e.res = qq[W-1:0];
        end
        return e;
    endfunction

    task automatic issue(input bit op, input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b, input bit chk);
        exp_t        e;
        int unsigned scnt;
        e          = model(op, sgn, a, b);
        start      = 1'b1;
        op_mul     = op;
        div_signed = sgn;
        src_a      = a;
        src_b      = b;
        #1;
        check("stall_accept", stall, e.dbz ? 1'b0 : 1'b1);
        e.due = cyc + (e.dbz ? 1 : W + 2);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start      = 1'b0;
        src_a      = $urandom;
        src_b      = $urandom;
        op_mul     = 1'($urandom);
        div_signed = 1'($urandom);
        if (e.dbz) begin
            check("div0_stall", stall, 1'b0);
        end else if (chk) begin
            scnt = 0;
            repeat (W + 1) begin
                if (stall) scnt++;
                @(negedge clk);
            end
            check("stall_cycles", scnt, W + 1);
            check("done_stall_low", stall, 1'b0);
            check("done_busy_high", busy, 1'b1);
        end
    endtask

    task automatic wait_idle(input bit disturb);
        int unsigned j;
        j = 0;
        while (busy && j < 100) begin
            if (disturb) begin
                start  = (j == 5 || j == 20);
                src_a  = $urandom;
                src_b  = $urandom;
                op_mul = 1'($urandom);
            end
            @(negedge clk);
            j++;
        end
        start = 1'b0;
        check("busy_falls", busy, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
            end else begin
                e = q.pop_front();
                check("result", result, e.res);
                check("div_by_zero", div_by_zero, e.dbz);
                check("done_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        reset      = 1'b1;
        start      = 1'b0;
        op_mul     = 1'b0;
        div_signed = 1'b0;
        src_a      = '0;
        src_b      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_result", result, 0);
        check("rst_dbz", div_by_zero, 1'b0);
        @(negedge clk);

        issue(1, 0, 7, 6, 1);                          wait_idle(0);
        issue(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);    wait_idle(0);
        issue(0, 0, 100, 7, 1);                        wait_idle(0);
        issue(0, 0, 32'hFFFFFFFF, 2, 0);               wait_idle(0);
        issue(0, 1, 32'hFFFFFF9C, 7, 0);               wait_idle(0);
        issue(0, 1, 32'hFFFFFF9C, 32'hFFFFFFF9, 0);    wait_idle(0);
        issue(0, 1, 32'h80000000, 32'hFFFFFFFF, 0);    wait_idle(0);
        issue(0, 0, 5, 0, 0);                          wait_idle(0);
        issue(0, 0, 100, 7, 0);                        wait_idle(0);

        // Start pulses while busy must be ignored; then a back-to-back start right after DONE.
        issue(1, 0, 7, 6, 0);                          wait_idle(1);
        issue(1, 0, 3, 5, 0);                          wait_idle(0);

        // Reset during a divide: outputs clear, no done for the aborted operation.
        issue(0, 0, 1000, 3, 0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_stall", stall, 1'b0);
        check("midrst_result", result, 0);
        check("midrst_dbz", div_by_zero, 1'b0);
        void'(q.pop_back());
        reset = 1'b0;
        repeat (3) @(negedge clk);
        issue(0, 0, 100, 7, 1);                        wait_idle(0);

        repeat (40) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = $urandom;
                default: rb = '1;
            endcase
            issue(1'($urandom), 1'($urandom), ra, rb, 0);
            wait_idle(0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle iterative multiply/divide unit with its own sequencing FSM, used by the single-cycle ARM core for MUL and UDIV/SDIV.
- Triggered by the decoder's Multiplication/Division strobes; DivMode selects signed or unsigned division.
- Asserts stall so the PC and register file hold until the result is ready.
- On done, the core writes `result` back through the ALUResult path.

Parameters:
WIDTH, 32, operand and result width in bits; also the iteration count.

Ports:
clk  in  1  core clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
op_mul  in  1  1 = multiply, 0 = divide; sampled with start
div_signed  in  1  1 = signed divide, 0 = unsigned (DivMode); sampled with start; ignored for multiply
src_a  in  WIDTH  multiplicand or dividend; sampled with start
src_b  in  WIDTH  multiplier or divisor; sampled with start
busy  out  1  high in RUN, FIXUP and DONE
stall  out  1  combinational: (IDLE & start & ~div-by-zero) | RUN | FIXUP
done  out  1  high for exactly one cycle, in state DONE
result  out  WIDTH  low WIDTH bits of the product, or the quotient; held until the next accepted start or reset
div_by_zero  out  1  valid with done; held alongside result

Behaviour:
- Reset, applied on any edge including mid-operation:
  - state = IDLE, iteration counter = 0.
  - busy = 0, done = 0, result = 0, div_by_zero = 0.
  - No done pulse is emitted for an aborted operation.
- FSM states are IDLE, RUN, FIXUP and DONE.
- IDLE:
  - start = 1 and div-by-zero (divide with src_b == 0) → DONE directly.
    - result = all-ones; div_by_zero = 1.
    - stall stays 0 in this case, so there is 1-edge latency.
  - start = 1 otherwise → RUN.
    - Latch operands and op into internal registers.
    - For a signed divide, latch the operand magnitudes plus quotient sign = sign(a) ^ sign(b).
    - Clear the counter and div_by_zero.
  - start = 0 → stay in IDLE.
- RUN: one iteration per edge, WIDTH edges total; counter runs 0 .. WIDTH-1.
  - Multiply uses shift-add. Keep a WIDTH-bit accumulator; only the low WIDTH bits are kept. Signedness is irrelevant for the low half.
  - Divide uses restoring division: shift the remainder:dividend pair left, trial-subtract the divisor, and set the quotient bit when there is no borrow.
  - When the counter reaches WIDTH-1 → FIXUP.
- FIXUP: one edge.
  - For a signed divide with a negative quotient sign, result = two's-complement negation of the quotient.
  - Otherwise result = product or quotient unchanged.
  - → DONE.
- DONE: done = 1 for this cycle only; → IDLE on the next edge unconditionally. start seen in DONE is ignored.
- Latency: done is asserted in the cycle after edge E0+WIDTH+1, where E0 is the edge that accepted start. This is 33 edges at the default WIDTH.
- While busy, start and operand changes are ignored; the latched operands are used.
- Signed division truncates toward zero.
- INT_MIN / -1 gives 0x80000000, with no trap and div_by_zero = 0.
- The remainder is not exported.

Decomposition:
- Shared package `muldiv_pkg`:
  - State enum: IDLE = 2'd0, RUN = 2'd1, FIXUP = 2'd2, DONE = 2'd3.
  - OP_MUL / OP_DIV constants.
  - DIV0_RESULT = all-ones.
- One sub-module, `muldiv_iter_core`:
  - Holds the accumulator/remainder, shift registers and the per-iteration add/subtract.
  - Controlled by load, step and op inputs.
- The top module keeps the FSM, the counter, the sign fixup and the output registers.

Test Plan:
- Multiply: start, op_mul = 1, a = 7, b = 6.
  - Required: stall is high for 33 cycles, then a single done with result = 42 and busy falls after DONE.
  - Repeat with a = 0xFFFFFFFF, b = 0xFFFFFFFF → result = 0x00000001.
- Unsigned divide: a = 100, b = 7, div_signed = 0 → result = 14, div_by_zero = 0.
  - Also a = 0xFFFFFFFF, b = 2 → result = 0x7FFFFFFF.
- Signed divide:
  - a = -100 (0xFFFFFF9C), b = 7 → result = 0xFFFFFFF2 (-14).
  - a = -100, b = -7 → 14.
  - a = 0x80000000, b = 0xFFFFFFFF → 0x80000000.
- Divide by zero: a = 5, b = 0 → done on the next cycle, result = 0xFFFFFFFF, div_by_zero = 1, stall never asserted.
  - A following valid start clears div_by_zero.
- Start while busy: pulse start with new operands at cycles 5 and 20 of a 7×6 multiply.
  - Required: they are ignored, result = 42, exactly one done.
  - Back-to-back start issued in the IDLE cycle after DONE is accepted.
- Reset mid-operation: assert reset at RUN iteration 10 of a divide.
  - Required: next cycle all outputs are 0 and the state is IDLE, with no done.
  - A fresh divide 100/7 afterwards yields 14 with full latency.
